lcd_cmd_sched: RTL and testbench
================================

Name: lcd_cmd_sched

Overview:
- Command scheduler in front of LCD_CTRL.
- Buffers host commands in a small FIFO and issues them to LCD_CTRL one at a time, honouring the LCD_CTRL busy handshake.
- Tracks completion of write-back commands via done, with a watchdog timeout.
- Lets a host burst commands without polling busy itself.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, ≥2).
- WRITE_CMD, 4'h0, opcode that makes LCD_CTRL write the image back to IRAM and pulse done.
- TIMEOUT, 1023, max cycles waited for done after WRITE_CMD issue.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- host_cmd  input  4  command opcode from host.
- host_valid  input  1  host_cmd valid.
- host_ready  output  1  FIFO can accept (count < DEPTH).
- lcd_busy  input  1  LCD_CTRL busy.
- lcd_done  input  1  LCD_CTRL done pulse.
- lcd_cmd  output  4  command to LCD_CTRL.
- lcd_cmd_valid  output  1  single-cycle issue strobe.
- fifo_count  output  log2(DEPTH)+1  current occupancy.
- frame_cnt  output  8  completed WRITE_CMD count, wraps 255->0.
- timeout_err  output  1  sticky watchdog flag.
- sched_idle  output  1  state==IDLE and FIFO empty.

Behaviour:
Reset (reset low, async):
- FIFO empty; pointers and count 0.
- lcd_cmd=0, lcd_cmd_valid=0, frame_cnt=0, timeout_err=0.
- state=IDLE, watchdog=0.
- host_ready=1, sched_idle=1.

FIFO:
- Push when host_valid && host_ready.
- host_ready is combinational: low iff count==DEPTH. With host_valid high while full, nothing is pushed and nothing is lost; the host stalls.
- Pop only on issue.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.

FSM (lcd_cmd and lcd_cmd_valid are registered):
- IDLE:
  - If FIFO non-empty and lcd_busy==0 at the posedge: lcd_cmd<=head, lcd_cmd_valid<=1, pop.
  - Next state is WAIT_DONE if head==WRITE_CMD (watchdog<=0), else GUARD.
  - Otherwise lcd_cmd_valid<=0 and stay.
- GUARD:
  - lcd_cmd_valid<=0, lcd_cmd holds.
  - One cycle only, then IDLE.
  - Covers the one-cycle delay before LCD_CTRL raises busy, preventing a double issue.
- WAIT_DONE:
  - lcd_cmd_valid<=0, no issue.
  - If lcd_done==1: frame_cnt++, go IDLE.
  - Else if watchdog==TIMEOUT: timeout_err<=1, go IDLE.
  - Else watchdog++.
  - Host pushes remain allowed.

Issue timing:
- lcd_cmd_valid is high for exactly one clk per command.
- Commands reach LCD_CTRL in push order.
- Minimum spacing between issues is 2 cycles: issue, then GUARD.
- Latency from push into an empty FIFO (LCD idle) to lcd_cmd_valid is 1 cycle: push at edge N, issue visible after edge N+1.

Other rules:
- lcd_done outside WAIT_DONE is ignored; frame_cnt does not change.
- timeout_err clears only on reset.
- lcd_busy high in IDLE holds the head command indefinitely; no watchdog applies in IDLE.
- Reset mid-operation (any state): immediate return to reset values; FIFO contents discarded.

Test Plan:
- Reset check: reset low mid-WAIT_DONE with FIFO count 3 -> all outputs at reset values at once; after release sched_idle=1, fifo_count=0.
- Burst order: push 1,2,3,WRITE_CMD back-to-back with lcd_busy low, model raising busy 1 cycle after each strobe for 2 cycles, done 5 cycles after WRITE_CMD.
  - Expect lcd_cmd_valid pulses carrying 1,2,3,0 in order, each one cycle wide.
  - frame_cnt=1, sched_idle=1.
- Full FIFO: hold lcd_busy high, push 10 commands -> host_ready low after 8 accepted, fifo_count=8.
  - Then release busy: exactly the 8 accepted commands issue in order; the remaining 2 are accepted as space frees.
- Guard: lcd_busy tied low with 2 queued non-write commands -> strobes are exactly 2 cycles apart, never consecutive.
- Timeout: TIMEOUT=15, issue WRITE_CMD, never pulse done -> timeout_err=1 exactly 16 cycles after the strobe, FSM back in IDLE, next queued command issues; frame_cnt stays 0.
- Stray done: pulse lcd_done while in IDLE -> frame_cnt unchanged. Separately, 256 completed frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/lcd_cmd_sched.sv
// Command scheduler in front of LCD_CTRL: queues host opcodes in a small FIFO
// and issues them one at a time, respecting the controller busy handshake and
// tracking write-back completion with a watchdog.
module lcd_cmd_sched #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [3:0]  WRITE_CMD = 4'h0,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               host_cmd,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic                     lcd_busy,
  input  logic                     lcd_done,
  output logic [3:0]               lcd_cmd,
  output logic                     lcd_cmd_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               frame_cnt,
  output logic                     timeout_err,
  output logic                     sched_idle
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [WW-1:0] WD_LIMIT   = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    WAIT_DONE
  } state_t;

  state_t          state, state_next;
  logic [3:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [WW-1:0]   watchdog, wd_next;
  logic [3:0]      cmd_next;
  logic            valid_next;
  logic [7:0]      frame_next;
  logic            terr_next;
  logic [3:0]      head;
  logic            empty, push, pop, issue, wd_expired;

  assign head       = mem[rd_ptr];
  assign empty      = (count == '0);
  assign host_ready = (count != FULL_COUNT);
  assign push       = host_valid && host_ready;
  assign issue      = (state == IDLE) && !empty && !lcd_busy;
  assign pop        = issue;
  assign wd_expired = (watchdog == WD_LIMIT);
  assign fifo_count = count;
  assign sched_idle = (state == IDLE) && empty;

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host_cmd;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      lcd_cmd       <= '0;
      lcd_cmd_valid <= 1'b0;
      watchdog      <= '0;
      frame_cnt     <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_next;
      lcd_cmd       <= cmd_next;
      lcd_cmd_valid <= valid_next;
      watchdog      <= wd_next;
      frame_cnt     <= frame_next;
      timeout_err   <= terr_next;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue) state_next = (head == WRITE_CMD) ? WAIT_DONE : GUARD;
      end
      GUARD: state_next = IDLE;
      WAIT_DONE: begin
        if (lcd_done || wd_expired) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values for the registered outputs, watchdog and frame counter
  always_comb begin
    cmd_next   = lcd_cmd;
    valid_next = 1'b0;
    wd_next    = watchdog;
    frame_next = frame_cnt;
    terr_next  = timeout_err;
    case (state)
      IDLE: begin
        if (issue) begin
          cmd_next   = head;
          valid_next = 1'b1;
          if (head == WRITE_CMD) wd_next = '0;
        end
      end
      WAIT_DONE: begin
        if (lcd_done)        frame_next = frame_cnt + 8'd1;
        else if (wd_expired) terr_next  = 1'b1;
        else                 wd_next    = watchdog + 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed bench for lcd_cmd_sched with a small LCD_CTRL busy/done model.
module tb_lcd_cmd_sched;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [3:0]  WR      = 4'h0;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic       lcd_busy;
  logic       lcd_done;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic [3:0] fifo_count;
  logic [7:0] frame_cnt;
  logic       timeout_err;
  logic       sched_idle;

  logic model_en;
  logic busy_force;
  logic done_force;
  logic model_busy = 1'b0;
  logic model_done = 1'b0;

  int         n_checks;
  int         n_fail;
  int         cyc = 0;
  logic [3:0] obs_q[$];
  int         obs_t[$];
  int         dbl_cnt = 0;
  logic       prev_v = 1'b0;
  int         since = 100;
  logic       wr_pend = 1'b0;

  assign lcd_busy = model_en ? model_busy : busy_force;
  assign lcd_done = model_en ? model_done : done_force;

  lcd_cmd_sched #(
    .DEPTH    (DEPTH),
    .WRITE_CMD(WR),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .host_cmd     (host_cmd),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .lcd_busy     (lcd_busy),
    .lcd_done     (lcd_done),
    .lcd_cmd      (lcd_cmd),
    .lcd_cmd_valid(lcd_cmd_valid),
    .fifo_count   (fifo_count),
    .frame_cnt    (frame_cnt),
    .timeout_err  (timeout_err),
    .sched_idle   (sched_idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Strobe monitor plus LCD_CTRL model: busy for 2 cycles starting 1 cycle
  // after each strobe, done pulse 5 cycles after a write strobe.
  always @(negedge clk) begin
    if (lcd_cmd_valid === 1'b1) begin
      obs_q.push_back(lcd_cmd);
      obs_t.push_back(cyc);
      if (prev_v) dbl_cnt++;
      since   = 0;
      wr_pend = (lcd_cmd == WR);
    end else if (since < 100) begin
      since++;
    end
    prev_v     = (lcd_cmd_valid === 1'b1);
    model_busy = (since == 1) || (since == 2);
    model_done = wr_pend && (since == 5);
    if (since >= 5) wr_pend = 1'b0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick; tick;
    n_checks++; if (lcd_cmd !== 4'h0) begin n_fail++; $display("FAIL rst_lcd_cmd: got %h expected 0", lcd_cmd); end
    n_checks++; if (lcd_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", lcd_cmd_valid); end
    n_checks++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_frame: got %0d expected 0", frame_cnt); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_terr: got %b expected 0", timeout_err); end
    n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", host_ready); end
    n_checks++; if (sched_idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b expected 1", sched_idle); end
    n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
    reset = 1'b1;
    tick;
    // write first, so the FSM sits in WAIT_DONE while three more queue up
    for (int i = 0; i < 4; i++) begin
      host_cmd   = 4'(i);
      host_valid = 1'b1;
      tick;
    end
    host_valid = 1'b0;
    n_checks++; if (fifo_count !== 4'd3) begin n_fail++; $display("FAIL mid_count: got %0d expected 3", fifo_count); end
    n_checks++; if (sched_idle !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got %b expected 0", sched_idle); end
    reset = 1'b0;
    #1;
    n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL async_count: got %0d expected 0", fifo_count); end
    n_checks++; if (lcd_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b expected 0", lcd_cmd_valid); end
    n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL async_ready: got %b expected 1", host_ready); end
    n_checks++; if (sched_idle !== 1'b1) begin n_fail++; $display("FAIL async_idle: got %b expected 1", sched_idle); end
    n_checks++; if (frame_cnt !== 8'd0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL async_stat: got frame %0d terr %b expected 0 0", frame_cnt, timeout_err); end
    tick;
    reset = 1'b1;
    tick; tick;
    n_checks++; if (sched_idle !== 1'b1 || fifo_count !== 4'd0) begin n_fail++; $display("FAIL post_rst: got idle %b count %0d expected 1 0", sched_idle, fifo_count); end
  endtask

  task automatic test_burst;
    logic [3:0] exp_b [4] = '{4'h1, 4'h2, 4'h3, 4'h0};
    int base, d0;
    bit ok;
    model_en = 1'b1;
    tick; tick;
    base = obs_q.size();
    d0   = dbl_cnt;
    for (int i = 0; i < 4; i++) begin
      host_cmd   = exp_b[i];
      host_valid = 1'b1;
      tick;
    end
    host_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      tick;
      if (sched_idle) ok = 1'b1;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL burst_drain: got busy after 100 cycles expected idle"); end
    n_checks++; if (obs_q.size() - base != 4) begin n_fail++; $display("FAIL burst_n: got %0d strobes expected 4", obs_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < obs_q.size()) begin
        n_checks++; if (obs_q[base+i] !== exp_b[i]) begin n_fail++; $display("FAIL burst_cmd%0d: got %h expected %h", i, obs_q[base+i], exp_b[i]); end
      end
    end
    n_checks++; if (dbl_cnt != d0) begin n_fail++; $display("FAIL burst_width: got %0d wide strobes expected 0", dbl_cnt - d0); end
    n_checks++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL burst_frame: got %0d expected 1", frame_cnt); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL burst_terr: got %b expected 0", timeout_err); end
    model_en = 1'b0;
  endtask

  task automatic test_full;
    int base, d0, idx;
    logic rdy;
    bit ok;
    busy_force = 1'b1;
    tick;
    base = obs_q.size();
    d0   = dbl_cnt;
    idx  = 0;
    for (int c = 0; c < 10; c++) begin
      host_cmd   = 4'(idx + 1);
      host_valid = 1'b1;
      rdy        = host_ready;
      tick;
      if (rdy) idx++;
    end
    n_checks++; if (idx != 8) begin n_fail++; $display("FAIL full_accepted: got %0d expected 8", idx); end
    n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", host_ready); end
    n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", fifo_count); end
    n_checks++; if (obs_q.size() != base) begin n_fail++; $display("FAIL full_held: got %0d strobes expected 0", obs_q.size() - base); end
    busy_force = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 80 && !ok; c++) begin
      host_cmd   = 4'(idx + 1);
      host_valid = (idx < 10);
      rdy        = host_ready;
      tick;
      if (rdy && idx < 10) idx++;
      if (idx == 10 && sched_idle) ok = 1'b1;
    end
    host_valid = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_drain: got idx %0d idle %b expected 10 1", idx, sched_idle); end
    n_checks++; if (obs_q.size() - base != 10) begin n_fail++; $display("FAIL full_n: got %0d strobes expected 10", obs_q.size() - base); end
    for (int i = 0; i < 10; i++) begin
      if (base + i < obs_q.size()) begin
        n_checks++; if (obs_q[base+i] !== 4'(i + 1)) begin n_fail++; $display("FAIL full_cmd%0d: got %h expected %h", i, obs_q[base+i], 4'(i + 1)); end
      end
    end
    n_checks++; if (dbl_cnt != d0) begin n_fail++; $display("FAIL full_width: got %0d wide strobes expected 0", dbl_cnt - d0); end
    n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_end: got %b expected 1", host_ready); end
  endtask

  task automatic test_guard;
    int base, d0;
    busy_force = 1'b0;
    tick;
    base = obs_q.size();
    d0   = dbl_cnt;
    host_cmd = 4'h5; host_valid = 1'b1; tick;
    host_cmd = 4'h6; tick;
    host_valid = 1'b0;
    repeat (6) tick;
    n_checks++; if (obs_q.size() - base != 2) begin n_fail++; $display("FAIL guard_n: got %0d strobes expected 2", obs_q.size() - base); end
    if (obs_q.size() - base >= 2) begin
      n_checks++; if (obs_q[base] !== 4'h5 || obs_q[base+1] !== 4'h6) begin n_fail++; $display("FAIL guard_order: got %h %h expected 5 6", obs_q[base], obs_q[base+1]); end
      n_checks++; if (obs_t[base+1] - obs_t[base] != 2) begin n_fail++; $display("FAIL guard_spacing: got %0d expected 2", obs_t[base+1] - obs_t[base]); end
    end
    n_checks++; if (dbl_cnt != d0) begin n_fail++; $display("FAIL guard_width: got %0d wide strobes expected 0", dbl_cnt - d0); end
    n_checks++; if (sched_idle !== 1'b1) begin n_fail++; $display("FAIL guard_idle: got %b expected 1", sched_idle); end
  endtask

  task automatic test_stray_done;
    done_force = 1'b1;
    tick;
    done_force = 1'b0;
    tick;
    n_checks++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL stray_frame: got %0d expected 1", frame_cnt); end
    n_checks++; if (lcd_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL stray_valid: got %b expected 0", lcd_cmd_valid); end
  endtask

  task automatic test_wrap;
    int pushed;
    logic rdy;
    bit ok;
    reset = 1'b0; tick;
    reset = 1'b1; tick;
    n_checks++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_start: got %0d expected 0", frame_cnt); end
    model_en = 1'b1;
    pushed = 0;
    ok = 1'b0;
    for (int c = 0; c < 4000 && !ok; c++) begin
      host_cmd   = WR;
      host_valid = (pushed < 255);
      rdy        = host_ready;
      tick;
      if (rdy && pushed < 255) pushed++;
      if (pushed == 255 && sched_idle) ok = 1'b1;
    end
    host_valid = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_drain: got pushed %0d idle %b expected 255 1", pushed, sched_idle); end
    n_checks++; if (frame_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d expected 255", frame_cnt); end
    host_valid = 1'b1;
    tick;
    host_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      tick;
      if (sched_idle) ok = 1'b1;
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_last: got busy after 50 cycles expected idle"); end
    n_checks++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d expected 0", frame_cnt); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL wrap_terr: got %b expected 0", timeout_err); end
    model_en = 1'b0;
  endtask

  task automatic test_timeout;
    bit early;
    busy_force = 1'b0;
    done_force = 1'b0;
    tick; tick;
    host_cmd = WR;   host_valid = 1'b1; tick;
    host_cmd = 4'h7; tick;
    host_valid = 1'b0;
    n_checks++; if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== WR) begin n_fail++; $display("FAIL to_issue: got valid %b cmd %h expected 1 0", lcd_cmd_valid, lcd_cmd); end
    early = 1'b0;
    repeat (15) begin
      tick;
      if (timeout_err !== 1'b0 || lcd_cmd_valid !== 1'b0) early = 1'b1;
    end
    n_checks++; if (early) begin n_fail++; $display("FAIL to_early: got flag or strobe before cycle 16 expected none"); end
    tick;
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b expected 1", timeout_err); end
    n_checks++; if (lcd_cmd_valid !== 1'b0 || fifo_count !== 4'd1) begin n_fail++; $display("FAIL to_pending: got valid %b count %0d expected 0 1", lcd_cmd_valid, fifo_count); end
    tick;
    n_checks++; if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== 4'h7) begin n_fail++; $display("FAIL to_next: got valid %b cmd %h expected 1 7", lcd_cmd_valid, lcd_cmd); end
    n_checks++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL to_frame: got %0d expected 0", frame_cnt); end
    repeat (4) tick;
    n_checks++; if (timeout_err !== 1'b1 || sched_idle !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got terr %b idle %b expected 1 1", timeout_err, sched_idle); end
    reset = 1'b0;
    #1;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b expected 0", timeout_err); end
    tick;
    reset = 1'b1;
    tick;
  endtask

  initial begin
    reset      = 1'b0;
    host_cmd   = 4'h0;
    host_valid = 1'b0;
    model_en   = 1'b0;
    busy_force = 1'b0;
    done_force = 1'b0;
    n_checks   = 0;
    n_fail     = 0;
    test_reset;
    test_burst;
    test_full;
    test_guard;
    test_stray_done;
    test_wrap;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
